// File: rtl/miriscv_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_decode_stage_if
// Brief    : Fetch-side, decode-side and pipeline-control signals of the decode stage
// Revision : 1.0
// ============================================================================
interface miriscv_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            f_valid_i;
    logic            f_ready_o;
    logic [31:0]     f_instr_i;
    logic [XLEN-1:0] f_pc_i;
    logic            kill_i;
    logic            ex_busy_i;
    logic            d_valid_o;
    logic            d_ready_i;
    logic [31:0]     d_instr_o;
    logic [XLEN-1:0] d_pc_o;
    logic [3:0]      d_alu_op_o;
    logic [2:0]      d_mdu_op_o;
    logic            d_mdu_req_o;
    logic            d_mem_req_o;
    logic            d_mem_we_o;
    logic [2:0]      d_mem_size_o;
    logic [2:0]      d_wb_src_sel_o;
    logic            d_wb_we_o;
    logic            d_rs1_re_o;
    logic            d_rs2_re_o;
    logic            d_op1_sel_o;
    logic            d_op2_sel_o;
    logic            d_branch_o;
    logic            d_jal_o;
    logic            d_jalr_o;
    logic            d_fence_o;
    logic            d_fencei_o;
    logic            d_csr_o;
    logic [1:0]      d_sys_op_o;
    logic            d_illegal_o;
    logic            fencei_flush_o;

    modport slave (
        input  f_valid_i, f_instr_i, f_pc_i, kill_i, ex_busy_i, d_ready_i,
        output f_ready_o, d_valid_o, d_instr_o, d_pc_o, d_alu_op_o, d_mdu_op_o,
               d_mdu_req_o, d_mem_req_o, d_mem_we_o, d_mem_size_o, d_wb_src_sel_o,
               d_wb_we_o, d_rs1_re_o, d_rs2_re_o, d_op1_sel_o, d_op2_sel_o,
               d_branch_o, d_jal_o, d_jalr_o, d_fence_o, d_fencei_o, d_csr_o,
               d_sys_op_o, d_illegal_o, fencei_flush_o
    );

    modport master (
        output f_valid_i, f_instr_i, f_pc_i, kill_i, ex_busy_i, d_ready_i,
        input  f_ready_o, d_valid_o, d_instr_o, d_pc_o, d_alu_op_o, d_mdu_op_o,
               d_mdu_req_o, d_mem_req_o, d_mem_we_o, d_mem_size_o, d_wb_src_sel_o,
               d_wb_we_o, d_rs1_re_o, d_rs2_re_o, d_op1_sel_o, d_op2_sel_o,
               d_branch_o, d_jal_o, d_jalr_o, d_fence_o, d_fencei_o, d_csr_o,
               d_sys_op_o, d_illegal_o, fencei_flush_o
    );
endinterface
`default_nettype wire

// File: rtl/miriscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_decode_stage
// Brief    : Registered RV32I(+M/Zicsr/Zifencei) decode stage with fence/trap serialisation
// Revision : 1.0
// ============================================================================
module miriscv_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit RV32M    = 1'b1,
    parameter bit ZICSR    = 1'b1,
    parameter bit ZIFENCEI = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    miriscv_decode_stage_if.slave dec_if
);
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_misc   = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam logic [2:0] c_wb_alu = 3'd0;
    localparam logic [2:0] c_wb_mdu = 3'd1;
    localparam logic [2:0] c_wb_lsu = 3'd2;
    localparam logic [2:0] c_wb_pc4 = 3'd3;
    localparam logic [2:0] c_wb_imm = 3'd4;
    localparam logic [2:0] c_wb_csr = 3'd5;

    localparam logic [1:0] c_st_run        = 2'd0;
    localparam logic [1:0] c_st_fence_wait = 2'd1;
    localparam logic [1:0] c_st_flush      = 2'd2;
    localparam logic [1:0] c_st_trap_wait  = 2'd3;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [3:0]      alu_op;
        logic [2:0]      mdu_op;
        logic            mdu_req;
        logic            mem_req;
        logic            mem_we;
        logic [2:0]      mem_size;
        logic [2:0]      wb_src;
        logic            wb_we;
        logic            rs1_re;
        logic            rs2_re;
        logic            op1_sel;
        logic            op2_sel;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            fence;
        logic            fencei;
        logic            csr;
        logic [1:0]      sys_op;
        logic            illegal;
    } decode_t;

    decode_t     w_dec;
    decode_t     r_dec;
    logic        w_ill;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [1:0]  r_state;
    logic        r_d_valid;
    logic        r_flush;
    logic        w_f_ready;
    logic        w_accept;
    logic        w_fence_done;

    assign w_instr  = dec_if.f_instr_i;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_funct7 = w_instr[31:25];

    // The full 7-bit opcode match also rejects compressed encodings (instr[1:0] != 11).
    always_comb begin
        w_ill       = 1'b0;
        w_dec       = '0;
        w_dec.instr = w_instr;
        w_dec.pc    = dec_if.f_pc_i;
        case (w_opcode)
            c_op_lui: begin
                w_dec.wb_we  = 1'b1;
                w_dec.wb_src = c_wb_imm;
            end
            c_op_auipc: begin
                w_dec.wb_we   = 1'b1;
                w_dec.wb_src  = c_wb_alu;
                w_dec.op1_sel = 1'b1;
                w_dec.op2_sel = 1'b1;
            end
            c_op_jal: begin
                w_dec.jal    = 1'b1;
                w_dec.wb_we  = 1'b1;
                w_dec.wb_src = c_wb_pc4;
            end
            c_op_jalr: begin
                w_dec.jalr   = 1'b1;
                w_dec.wb_we  = 1'b1;
                w_dec.wb_src = c_wb_pc4;
                w_dec.rs1_re = 1'b1;
                w_ill        = (w_funct3 != 3'b000);
            end
            c_op_branch: begin
                w_dec.branch = 1'b1;
                w_dec.rs1_re = 1'b1;
                w_dec.rs2_re = 1'b1;
                w_ill        = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            c_op_load: begin
                w_dec.mem_req  = 1'b1;
                w_dec.mem_size = w_funct3;
                w_dec.wb_we    = 1'b1;
                w_dec.wb_src   = c_wb_lsu;
                w_dec.rs1_re   = 1'b1;
                w_dec.op2_sel  = 1'b1;
                w_ill          = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
            end
            c_op_store: begin
                w_dec.mem_req  = 1'b1;
                w_dec.mem_we   = 1'b1;
                w_dec.mem_size = w_funct3;
                w_dec.rs1_re   = 1'b1;
                w_dec.rs2_re   = 1'b1;
                w_dec.op2_sel  = 1'b1;
                w_ill          = w_funct3[2] || (w_funct3 == 3'b011);
            end
            c_op_opimm: begin
                w_dec.wb_we   = 1'b1;
                w_dec.rs1_re  = 1'b1;
                w_dec.op2_sel = 1'b1;
                w_dec.alu_op  = {1'b0, w_funct3};
                // funct7 only qualifies the shift-immediate forms; elsewhere it is immediate data.
                if (w_funct3 == 3'b001) begin
                    w_ill = (w_funct7 != 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    if (w_funct7 == 7'b0100000) w_dec.alu_op = {1'b1, w_funct3};
                    else if (w_funct7 != 7'b0000000) w_ill = 1'b1;
                end
            end
            c_op_op: begin
                w_dec.wb_we  = 1'b1;
                w_dec.rs1_re = 1'b1;
                w_dec.rs2_re = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_dec.alu_op = {1'b0, w_funct3};
                end else if ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
                    w_dec.alu_op = {1'b1, w_funct3};
                end else if ((w_funct7 == 7'b0000001) && RV32M) begin
                    w_dec.mdu_req = 1'b1;
                    w_dec.mdu_op  = w_funct3;
                    w_dec.wb_src  = c_wb_mdu;
                end else begin
                    w_ill = 1'b1;
                end
            end
            c_op_misc: begin
                if (w_funct3 == 3'b000) w_dec.fence = 1'b1;
                else if ((w_funct3 == 3'b001) && ZIFENCEI) w_dec.fencei = 1'b1;
                else w_ill = 1'b1;
            end
            c_op_system: begin
                if (!ZICSR) begin
                    w_ill = 1'b1;
                end else if (w_funct3 == 3'b000) begin
                    case (w_instr)
                        32'h00000073: w_dec.sys_op = 2'd1;
                        32'h00100073: w_dec.sys_op = 2'd2;
                        32'h30200073: w_dec.sys_op = 2'd3;
                        default:      w_ill        = 1'b1;
                    endcase
                end else if (w_funct3 == 3'b100) begin
                    w_ill = 1'b1;
                end else begin
                    w_dec.csr    = 1'b1;
                    w_dec.wb_we  = 1'b1;
                    w_dec.wb_src = c_wb_csr;
                    w_dec.rs1_re = !w_funct3[2];
                end
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_dec         = '0;
            w_dec.instr   = w_instr;
            w_dec.pc      = dec_if.f_pc_i;
            w_dec.illegal = 1'b1;
        end
    end

    assign w_f_ready    = (r_state == c_st_run) && (!r_d_valid || dec_if.d_ready_i) && !dec_if.kill_i;
    assign w_accept     = dec_if.f_valid_i && w_f_ready;
    assign w_fence_done = (!r_d_valid || dec_if.d_ready_i) && !dec_if.ex_busy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= c_st_run;
            r_d_valid <= 1'b0;
            r_flush   <= 1'b0;
            r_dec     <= '0;
        end else if (dec_if.kill_i) begin
            r_state   <= c_st_run;
            r_d_valid <= 1'b0;
            r_flush   <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (w_accept) begin
                r_dec     <= w_dec;
                r_d_valid <= 1'b1;
            end else if (r_d_valid && dec_if.d_ready_i) begin
                r_d_valid <= 1'b0;
            end
            case (r_state)
                c_st_run: begin
                    if (w_accept && (w_dec.fence || w_dec.fencei)) r_state <= c_st_fence_wait;
                    else if (w_accept && (w_dec.illegal || (w_dec.sys_op != 2'd0))) r_state <= c_st_trap_wait;
                end
                c_st_fence_wait: begin
                    // No accepts happen here, so r_dec still describes the fence being drained.
                    if (w_fence_done) begin
                        if (r_dec.fencei) begin
                            r_state <= c_st_flush;
                            r_flush <= 1'b1;
                        end else begin
                            r_state <= c_st_run;
                        end
                    end
                end
                c_st_flush:     r_state <= c_st_run;
                c_st_trap_wait: r_state <= c_st_trap_wait;
            endcase
        end
    end

    assign dec_if.f_ready_o      = w_f_ready;
    assign dec_if.d_valid_o      = r_d_valid;
    assign dec_if.d_instr_o      = r_dec.instr;
    assign dec_if.d_pc_o         = r_dec.pc;
    assign dec_if.d_alu_op_o     = r_dec.alu_op;
    assign dec_if.d_mdu_op_o     = r_dec.mdu_op;
    assign dec_if.d_mdu_req_o    = r_dec.mdu_req;
    assign dec_if.d_mem_req_o    = r_dec.mem_req;
    assign dec_if.d_mem_we_o     = r_dec.mem_we;
    assign dec_if.d_mem_size_o   = r_dec.mem_size;
    assign dec_if.d_wb_src_sel_o = r_dec.wb_src;
    assign dec_if.d_wb_we_o      = r_dec.wb_we;
    assign dec_if.d_rs1_re_o     = r_dec.rs1_re;
    assign dec_if.d_rs2_re_o     = r_dec.rs2_re;
    assign dec_if.d_op1_sel_o    = r_dec.op1_sel;
    assign dec_if.d_op2_sel_o    = r_dec.op2_sel;
    assign dec_if.d_branch_o     = r_dec.branch;
    assign dec_if.d_jal_o        = r_dec.jal;
    assign dec_if.d_jalr_o       = r_dec.jalr;
    assign dec_if.d_fence_o      = r_dec.fence;
    assign dec_if.d_fencei_o     = r_dec.fencei;
    assign dec_if.d_csr_o        = r_dec.csr;
    assign dec_if.d_sys_op_o     = r_dec.sys_op;
    assign dec_if.d_illegal_o    = r_dec.illegal;
    assign dec_if.fencei_flush_o = r_flush;
endmodule
`default_nettype wire

// File: doc/miriscv_decode_stage.md
Name: miriscv_decode_stage

Overview:
Registered decode pipeline stage between fetch and execute in the miriscv core. Decodes RV32I plus optional M, Zicsr and Zifencei into a registered control bundle, with valid/ready handshakes on both sides. A serialisation FSM drains the pipeline for FENCE/FENCE.I and pulses a fetch flush after FENCE.I. After issuing an illegal instruction the stage holds until the trap kill arrives.

Parameters:
XLEN, 32, data/PC width
RV32M, 1, 1 = OP with funct7=0000001 is legal (MDU request); 0 = illegal
ZICSR, 1, 1 = SYSTEM opcode (CSRRW/S/C[I], ECALL, EBREAK, MRET) legal; 0 = whole SYSTEM opcode illegal
ZIFENCEI, 1, 1 = MISC-MEM funct3=001 (FENCE.I) legal; 0 = illegal

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
f_valid_i  in  1  fetch word valid
f_ready_o  out  1  stage accepts the fetch word this cycle
f_instr_i  in  32  instruction
f_pc_i  in  XLEN  instruction PC
kill_i  in  1  pipeline flush from branch/trap unit
ex_busy_i  in  1  execute/memory stages still hold older instructions
d_valid_o  out  1  decoded bundle valid
d_ready_i  in  1  execute accepts bundle
d_instr_o / d_pc_o  out  32 / XLEN  registered copies
d_alu_op_o  out  4  {funct7[5] qualifier, funct3}; 4'b0000 (ADD) for non-ALU opcodes
d_mdu_op_o  out  3  funct3; d_mdu_req_o out 1
d_mem_req_o, d_mem_we_o  out  1  each; d_mem_size_o out 3 (funct3)
d_wb_src_sel_o  out  3  0 ALU, 1 MDU, 2 LSU, 3 PC+4, 4 IMM, 5 CSR
d_wb_we_o, d_rs1_re_o, d_rs2_re_o, d_op1_sel_o, d_op2_sel_o  out  1 each
d_branch_o, d_jal_o, d_jalr_o, d_fence_o, d_fencei_o, d_csr_o  out  1 each
d_sys_op_o  out  2  0 none, 1 ECALL, 2 EBREAK, 3 MRET
d_illegal_o  out  1  illegal instruction
fencei_flush_o  out  1  one-cycle fetch flush/refetch request

Behaviour:
- Reset (async, rst_i=1): d_valid_o=0, all d_* outputs 0, fencei_flush_o=0, FSM=RUN. f_ready_o=1 from the first cycle after release.
- Decode rules match the core's RV32I legality checks: instr[1:0]!=11, unknown opcode, bad funct3 on LOAD/STORE/BRANCH/JALR/FENCE, bad funct7 on OP/OPIMM shifts are all illegal.
- SYSTEM legality: CSR funct3 in {001,010,011,101,110,111}. funct3=000 is legal only for exact ECALL 0x00000073, EBREAK 0x00100073 or MRET 0x30200073.
- When d_illegal_o=1: d_mem_req_o, d_mem_we_o, d_wb_we_o, d_mdu_req_o, d_rs1_re_o, d_rs2_re_o, d_fence_o, d_fencei_o and d_csr_o are all 0.
- Latency: exactly 1 cycle from accept to d_valid_o.
- Handshake:
  - f_ready_o = (state==RUN) && (!d_valid_o || d_ready_i) && !kill_i.
  - Accept = f_valid_i && f_ready_o, which loads the bundle and sets d_valid_o.
  - d_ready_i && d_valid_o with no accept clears d_valid_o.
  - Bundle outputs stay stable while d_valid_o && !d_ready_i.
- FSM states: RUN, FENCE_WAIT, FLUSH, TRAP_WAIT.
  - RUN -> FENCE_WAIT on accepting FENCE or FENCE.I; the fence itself is issued normally.
  - FENCE_WAIT: f_ready_o=0. Exit once the fence bundle has been consumed and ex_busy_i==0 in the same or a later cycle. Exit goes to RUN for FENCE, FLUSH for FENCE.I.
  - FLUSH: fencei_flush_o=1 for exactly one cycle, f_ready_o=0, then RUN.
  - RUN -> TRAP_WAIT on accepting an illegal instruction, ECALL, EBREAK or MRET. Hold f_ready_o=0 until kill_i.
- kill_i has highest priority in every state: next cycle d_valid_o=0, state=RUN, fencei_flush_o=0, and no accept occurs in the kill cycle.
- Reset mid-FENCE_WAIT or mid-bundle-stall: all state is dropped immediately; no flush pulse is generated.
- d_op1_sel_o=1 only for AUIPC. d_op2_sel_o=1 for OPIMM, AUIPC, LOAD, STORE.

Test Plan:
- ADD 0x002081B3 then SUB 0x402081B3 back-to-back, d_ready_i=0 for 3 cycles on the first -> d_alu_op_o=0000 held stable 3 cycles, f_ready_o=0 during stall; SUB then gives 1000; no instruction lost or duplicated.
- MUL 0x022081B3 with RV32M=0 -> d_illegal_o=1, d_mdu_req_o=0, d_wb_we_o=0, TRAP_WAIT. With RV32M=1 -> d_mdu_req_o=1, d_wb_src_sel_o=1.
- FENCE.I 0x0000100F with ex_busy_i high 4 cycles after consume -> f_ready_o=0 throughout, fencei_flush_o=1 for exactly one cycle after ex_busy_i falls, then f_ready_o=1.
- CSRRW 0x30029073 -> d_csr_o=1, d_wb_src_sel_o=5. With ZICSR=0 -> illegal. ECALL -> d_sys_op_o=1 and TRAP_WAIT until kill_i.
- kill_i asserted in the same cycle as f_valid_i with a valid LW -> no accept, d_valid_o=0 next cycle.
- rst_i asserted asynchronously mid-FENCE_WAIT -> outputs 0 immediately, no fencei_flush_o pulse, f_ready_o=1 after release.
- Word 0x00000000 (instr[1:0]=00) -> d_illegal_o=1, state TRAP_WAIT.
